// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control FSM states, instruction field encodings
// and the writeback source selector used by the register-file producer.
package mips_pkg;

    typedef enum logic [2:0] {
        FETCH_INSTR   = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100
    } state_t;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'b000000,
        OP_REGIMM  = 6'b000001,
        OP_J       = 6'b000010,
        OP_JAL     = 6'b000011,
        OP_BEQ     = 6'b000100,
        OP_BNE     = 6'b000101,
        OP_BLEZ    = 6'b000110,
        OP_BGTZ    = 6'b000111,
        OP_ADDI    = 6'b001000,
        OP_ADDIU   = 6'b001001,
        OP_SLTI    = 6'b001010,
        OP_SLTIU   = 6'b001011,
        OP_ANDI    = 6'b001100,
        OP_ORI     = 6'b001101,
        OP_XORI    = 6'b001110,
        OP_LUI     = 6'b001111,
        OP_LB      = 6'b100000,
        OP_LH      = 6'b100001,
        OP_LWL     = 6'b100010,
        OP_LW      = 6'b100011,
        OP_LBU     = 6'b100100,
        OP_LHU     = 6'b100101,
        OP_LWR     = 6'b100110,
        OP_SB      = 6'b101000,
        OP_SH      = 6'b101001,
        OP_SWL     = 6'b101010,
        OP_SW      = 6'b101011,
        OP_SWR     = 6'b101110
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL   = 6'b000000,
        FN_JR    = 6'b001000,
        FN_JALR  = 6'b001001,
        FN_MFHI  = 6'b010000,
        FN_MTHI  = 6'b010001,
        FN_MFLO  = 6'b010010,
        FN_MTLO  = 6'b010011,
        FN_MULT  = 6'b011000,
        FN_MULTU = 6'b011001,
        FN_DIV   = 6'b011010,
        FN_DIVU  = 6'b011011,
        FN_ADDU  = 6'b100001
    } funct_t;

    typedef enum logic [4:0] {
        RT_BLTZ   = 5'b00000,
        RT_BGEZ   = 5'b00001,
        RT_BLTZAL = 5'b10000,
        RT_BGEZAL = 5'b10001
    } regimm_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LINK = 2'd1,
        SRC_MEM  = 2'd2
    } wb_src_t;

    localparam logic [4:0] LINK_REG = 5'd31;

    function automatic logic is_load(input opcode_t op);
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_merge.sv
// Little-endian lane extraction and LWL/LWR merge of the captured memory word
// against the old rt contents.
module load_merge
    import mips_pkg::*;
(
    input  opcode_t     opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mdr,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = mdr[7:0];
            2'd1:    byte_sel = mdr[15:8];
            2'd2:    byte_sel = mdr[23:16];
            default: byte_sel = mdr[31:24];
        endcase
        half_sel = addr_lo[1] ? mdr[31:16] : mdr[15:0];
    end

    always_comb begin
        result = mdr;
        case (opcode)
            OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: result = {24'h000000, byte_sel};
            OP_LH:  result = {{16{half_sel[15]}}, half_sel};
            OP_LHU: result = {16'h0000, half_sel};
            OP_LWL: begin
                case (addr_lo)
                    2'd0:    result = {mdr[7:0],  rt_old[23:0]};
                    2'd1:    result = {mdr[15:0], rt_old[15:0]};
                    2'd2:    result = {mdr[23:0], rt_old[7:0]};
                    default: result = mdr;
                endcase
            end
            OP_LWR: begin
                case (addr_lo)
                    2'd0:    result = mdr;
                    2'd1:    result = {rt_old[31:24], mdr[31:8]};
                    2'd2:    result = {rt_old[31:16], mdr[31:16]};
                    default: result = {rt_old[31:8],  mdr[31:24]};
                endcase
            end
            default: result = mdr;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port producer: decodes the destination, captures load
// data in MEMORY_ACCESS and issues a single write beat per WRITE_BACK visit.
module writeback_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic [31:0] instr,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus8,
    input  logic [31:0] rt_old,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        RegWrite,
    output logic [4:0]  writeR,
    output logic [31:0] writedata
);

    opcode_t     op;
    funct_t      fn;
    regimm_t     rimm;
    state_t      cur_state;
    logic [4:0]  rd_idx;
    logic [4:0]  rt_idx;

    logic [31:0] mdr_q, mdr_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        done_q, done_d;

    logic        has_dest;
    logic [4:0]  dest;
    wb_src_t     src;
    logic [31:0] load_val;
    logic [31:0] wb_val;

    logic [9:0]  unused_instr_bits;

    assign op        = opcode_t'(instr[31:26]);
    assign fn        = funct_t'(instr[5:0]);
    assign rimm      = regimm_t'(instr[20:16]);
    assign rt_idx    = instr[20:16];
    assign rd_idx    = instr[15:11];
    assign cur_state = state_t'(state);

    assign unused_instr_bits = {instr[25:21], instr[10:6]};

    always_comb begin
        has_dest = 1'b0;
        dest     = '0;
        src      = SRC_ALU;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_JR, FN_MTHI, FN_MTLO,
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: has_dest = 1'b0;
                    FN_JALR: begin
                        has_dest = 1'b1;
                        dest     = rd_idx;
                        src      = SRC_LINK;
                    end
                    default: begin
                        has_dest = 1'b1;
                        dest     = rd_idx;
                    end
                endcase
            end
            OP_REGIMM: begin
                if (rimm == RT_BGEZAL || rimm == RT_BLTZAL) begin
                    has_dest = 1'b1;
                    dest     = LINK_REG;
                    src      = SRC_LINK;
                end
            end
            OP_JAL: begin
                has_dest = 1'b1;
                dest     = LINK_REG;
                src      = SRC_LINK;
            end
            default: begin
                if (is_load(op)) begin
                    has_dest = 1'b1;
                    dest     = rt_idx;
                    src      = SRC_MEM;
                end else if (instr[31:29] == 3'b001) begin
                    has_dest = 1'b1;
                    dest     = rt_idx;
                end
            end
        endcase
    end

    load_merge u_load_merge (
        .opcode  (op),
        .addr_lo (addr_lo_q),
        .mdr     (mdr_q),
        .rt_old  (rt_old),
        .result  (load_val)
    );

    always_comb begin
        case (src)
            SRC_LINK: wb_val = pc_plus8;
            SRC_MEM:  wb_val = load_val;
            default:  wb_val = alu_result;
        endcase
    end

    always_comb begin
        mdr_d     = mdr_q;
        addr_lo_d = addr_lo_q;
        if (cur_state == MEMORY_ACCESS && !waitrequest) begin
            mdr_d     = readdata;
            addr_lo_d = alu_result[1:0];
        end
        done_d = (cur_state == WRITE_BACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdr_q     <= '0;
            addr_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            mdr_q     <= mdr_d;
            addr_lo_q <= addr_lo_d;
            done_q    <= done_d;
        end
    end

    // Reset gates the outputs combinationally so no beat escapes in the reset cycle.
    always_comb begin
        RegWrite  = 1'b0;
        writeR    = '0;
        writedata = '0;
        if (cur_state == WRITE_BACK && !reset && has_dest) begin
            writeR    = dest;
            writedata = wb_val;
            RegWrite  = !done_q && (dest != 5'd0);
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: table of single-instruction vectors plus
// hand-written stall, held-WRITE_BACK and reset sequences.
module tb_writeback_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  state;
    logic [31:0] instr;
    logic [31:0] alu_result;
    logic [31:0] pc_plus8;
    logic [31:0] rt_old;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        RegWrite;
    logic [4:0]  writeR;
    logic [31:0] writedata;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_unit dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .instr       (instr),
        .alu_result  (alu_result),
        .pc_plus8    (pc_plus8),
        .rt_old      (rt_old),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .RegWrite    (RegWrite),
        .writeR      (writeR),
        .writedata   (writedata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] pc8;
        logic [31:0] rt_old;
        logic [31:0] rdata;
        logic        exp_we;
        logic [4:0]  exp_wr;
        logic [31:0] exp_wd;
        logic        chk_data;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        instr = v.instr; alu_result = v.alu; pc_plus8 = v.pc8;
        rt_old = v.rt_old; readdata = v.rdata; waitrequest = 1'b0;
        state = DECODE;
        @(negedge clk);
        state = EXECUTE;
        @(negedge clk);
        state = MEMORY_ACCESS;
        #1;
        check({v.name, "_mem_we"}, {31'd0, RegWrite}, 32'd0);
        @(negedge clk);
        state = WRITE_BACK;
        readdata = 32'hBADBADBA;
        #1;
        check({v.name, "_we"}, {31'd0, RegWrite}, {31'd0, v.exp_we});
        if (v.chk_data) begin
            check({v.name, "_wr"}, {27'd0, writeR}, {27'd0, v.exp_wr});
            check({v.name, "_wd"}, writedata, v.exp_wd);
        end
        @(negedge clk);
        state = FETCH_INSTR;
    endtask

    initial begin
        vecs[0]  = '{"lw",      32'h8C080100, 32'h00000100, 32'h0, 32'h0,        32'hDEADBEEF, 1'b1, 5'd8,  32'hDEADBEEF, 1'b1};
        vecs[1]  = '{"lb_k3",   32'h80090103, 32'h00000103, 32'h0, 32'h0,        32'h80123456, 1'b1, 5'd9,  32'hFFFFFF80, 1'b1};
        vecs[2]  = '{"lbu_k3",  32'h900A0103, 32'h00000103, 32'h0, 32'h0,        32'h80123456, 1'b1, 5'd10, 32'h00000080, 1'b1};
        vecs[3]  = '{"lh_k2",   32'h840B0102, 32'h00000102, 32'h0, 32'h0,        32'h80123456, 1'b1, 5'd11, 32'hFFFF8012, 1'b1};
        vecs[4]  = '{"lhu_k0",  32'h940C0100, 32'h00000100, 32'h0, 32'h0,        32'h80128456, 1'b1, 5'd12, 32'h00008456, 1'b1};
        vecs[5]  = '{"lwl_k1",  32'h880D0101, 32'h00000101, 32'h0, 32'h11223344, 32'hAABBCCDD, 1'b1, 5'd13, 32'hCCDD3344, 1'b1};
        vecs[6]  = '{"lwr_k2",  32'h980E0102, 32'h00000102, 32'h0, 32'h11223344, 32'hAABBCCDD, 1'b1, 5'd14, 32'h1122AABB, 1'b1};
        vecs[7]  = '{"bgezal",  32'h04110000, 32'h00000000, 32'hBFC00010, 32'h0, 32'h0,        1'b1, 5'd31, 32'hBFC00010, 1'b1};
        vecs[8]  = '{"beq",     32'h10110000, 32'h00000000, 32'hBFC00010, 32'h0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0};
        vecs[9]  = '{"addiu_0", 32'h24000005, 32'h00000005, 32'h0, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        1'b0};
        vecs[10] = '{"addu",    32'h00221821, 32'h12345678, 32'h0, 32'h0,        32'h0,        1'b1, 5'd3,  32'h12345678, 1'b1};
        vecs[11] = '{"jal",     32'h0C000010, 32'h00000000, 32'h00400008, 32'h0, 32'h0,        1'b1, 5'd31, 32'h00400008, 1'b1};
        vecs[12] = '{"jalr",    32'h00802809, 32'h00000000, 32'h00400020, 32'h0, 32'h0,        1'b1, 5'd5,  32'h00400020, 1'b1};
        vecs[13] = '{"mult",    32'h00220018, 32'h00000007, 32'h0, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        1'b0};
        vecs[14] = '{"bltzal",  32'h04100000, 32'h00000000, 32'h00400100, 32'h0, 32'h0,        1'b1, 5'd31, 32'h00400100, 1'b1};
        vecs[15] = '{"bgez",    32'h04010000, 32'h00000000, 32'h00400100, 32'h0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b0};
        vecs[16] = '{"lui",     32'h3C07ABCD, 32'hABCD0000, 32'h0, 32'h0,        32'h0,        1'b1, 5'd7,  32'hABCD0000, 1'b1};
        vecs[17] = '{"lb_k0",   32'h80090100, 32'h00000100, 32'h0, 32'h0,        32'h80123456, 1'b1, 5'd9,  32'h00000056, 1'b1};

        // Reset held in WRITE_BACK with a writing instruction: outputs stay zero.
        reset = 1'b1; state = WRITE_BACK; instr = 32'h8C080100; alu_result = 32'h100;
        pc_plus8 = '0; rt_old = '0; readdata = 32'h12345678; waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", {31'd0, RegWrite}, 32'd0);
        check("rst_wr", {27'd0, writeR}, 32'd0);
        check("rst_wd", writedata, 32'd0);
        reset = 1'b0; state = FETCH_INSTR;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Three stalled cycles then a clean capture; WRITE_BACK held two cycles.
        @(negedge clk);
        instr = 32'h8C040200; alu_result = 32'h200; state = MEMORY_ACCESS;
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            readdata = 32'hBAD00000 + i;
            @(negedge clk);
        end
        waitrequest = 1'b0; readdata = 32'h00000055;
        @(negedge clk);
        state = WRITE_BACK; readdata = 32'hDEADDEAD;
        #1;
        check("stall_we", {31'd0, RegWrite}, 32'd1);
        check("stall_wr", {27'd0, writeR}, 32'd4);
        check("stall_wd", writedata, 32'h00000055);
        @(negedge clk);
        #1;
        check("wb_hold_we", {31'd0, RegWrite}, 32'd0);
        @(negedge clk);
        state = FETCH_INSTR;

        // Two clean MEMORY_ACCESS cycles: the later one wins.
        @(negedge clk);
        state = MEMORY_ACCESS; waitrequest = 1'b0; readdata = 32'h00000011;
        @(negedge clk);
        readdata = 32'h00000022;
        @(negedge clk);
        state = WRITE_BACK;
        #1;
        check("overwrite_wd", writedata, 32'h00000022);
        @(negedge clk);
        state = FETCH_INSTR;

        // Capture followed by a stalled cycle: the stall must not disturb mdr.
        @(negedge clk);
        state = MEMORY_ACCESS; waitrequest = 1'b0; readdata = 32'h00000066;
        @(negedge clk);
        waitrequest = 1'b1; readdata = 32'h00000BAD;
        @(negedge clk);
        state = WRITE_BACK; waitrequest = 1'b0;
        #1;
        check("late_stall_wd", writedata, 32'h00000066);
        @(negedge clk);
        state = FETCH_INSTR;

        // Reset in WRITE_BACK: no beat that cycle, mdr and done cleared after.
        @(negedge clk);
        instr = 32'h8C060300; alu_result = 32'h300;
        state = MEMORY_ACCESS; readdata = 32'h00000077;
        @(negedge clk);
        state = WRITE_BACK; reset = 1'b1;
        #1;
        check("wb_rst_we", {31'd0, RegWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_we", {31'd0, RegWrite}, 32'd1);
        check("post_rst_mdr", writedata, 32'd0);
        @(negedge clk);
        state = FETCH_INSTR;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
